// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults and sizing helpers for the elastic pipeline register chain.
// Build option: PIPE_NEGEDGE_EN moves every stage/count register to the falling clock edge.
package pipe_reg_chain_pkg;

  localparam int PIPE_WIDTH_DEF = 9;
  localparam int PIPE_DEPTH_DEF = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic stage: valid bit plus data word, loaded when the chain advances into it.
// Build option: PIPE_NEGEDGE_EN selects the falling clock edge for this register.
module pipe_slot #(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

`ifdef PIPE_NEGEDGE_EN
  always_ff @(negedge clk or posedge rst) begin
`else
  always_ff @(posedge clk or posedge rst) begin
`endif
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (load) begin
        r_valid <= d_valid;
      end
      // Advancing with no incoming item empties the slot but keeps the old word.
      if (load && d_valid && !flush) begin
        r_data <= d_data;
      end
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage valid/ready register chain with flush and occupancy count.
// Build option: PIPE_NEGEDGE_EN updates all stages and count on the falling clock edge.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH_DEF,
  parameter int               DEPTH     = PIPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_d_valid;
  logic [WIDTH-1:0] w_data   [DEPTH];
  logic [WIDTH-1:0] w_d_data [DEPTH];
  logic             w_up;
  logic             w_dn;
  logic [CNT_W-1:0] r_count;

  // Stage k moves when the output drains or any stage from k onward has a hole.
  always_comb begin
    logic v_adv;
    for (int k = 0; k < DEPTH; k++) begin
      v_adv = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        v_adv = v_adv | ~w_valid[j];
      end
      w_adv[k] = v_adv;
    end
  end

  always_comb begin
    w_d_valid[0] = in_valid;
    w_d_data[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_d_valid[k] = w_valid[k-1];
      w_d_data[k]  = w_data[k-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .load    (w_adv[g]),
      .d_valid (w_d_valid[g]),
      .d_data  (w_d_data[g]),
      .valid   (w_valid[g]),
      .data    (w_data[g])
    );
  end

  assign in_ready  = w_adv[0] & ~flush;
  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];
  assign w_up      = in_valid & in_ready;
  assign w_dn      = out_valid & out_ready;

`ifdef PIPE_NEGEDGE_EN
  always_ff @(negedge clk or posedge rst) begin
`else
  always_ff @(posedge clk or posedge rst) begin
`endif
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_up && !w_dn) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_up && w_dn) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
